sram_ctrl: RTL and testbench

- Synchronous initiator for the 64K x 8 asynchronous SRAM on the clockport side; this is the engine that drives the SRAM's A, D, CS, WE and OE pins.
- Converts a single-beat valid/ready request port, used by the clockport/Pi bridge logic, into SRAM read and write cycles.
- Setup, strobe width and hold are programmable in whole clock cycles.
- Guarantees that WE and OE never overlap and that the data bus is never contended.

---
 rtl/sram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-beat request port to asynchronous 64K x 8 SRAM cycle engine
module sram_ctrl #(
  parameter int unsigned SETUP    = 1,
  parameter int unsigned WE_WIDTH = 2,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned HOLD     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] sram_a,
  output logic [7:0]  sram_d_out,
  output logic        sram_d_oe,
  input  logic [7:0]  sram_d_in,
  output logic        sram_cs_n,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  // Timing values are loaded minus one so the counter expires on its last cycle.
  if (SETUP < 1 || SETUP > 255 || WE_WIDTH < 1 || WE_WIDTH > 255 ||
      RD_WAIT < 1 || RD_WAIT > 255 || HOLD < 1 || HOLD > 255) begin : g_bad_timing
    $error("sram_ctrl: SETUP, WE_WIDTH, RD_WAIT and HOLD must each be in 1..255");
  end

  localparam logic [7:0] SETUP_M1 = 8'(SETUP - 1);
  localparam logic [7:0] WE_M1    = 8'(WE_WIDTH - 1);
  localparam logic [7:0] RD_M1    = 8'(RD_WAIT - 1);
  localparam logic [7:0] HOLD_M1  = 8'(HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_SETUP,
    RD_STROBE,
    RD_TURN
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] sram_a_q, sram_a_d;
  logic [7:0]  sram_d_out_q, sram_d_out_d;
  logic        sram_d_oe_q, sram_d_oe_d;
  logic        sram_cs_n_q, sram_cs_n_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic        sram_oe_n_q, sram_oe_n_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        cnt_done;

  assign cnt_done = (cnt_q == 8'd0);

  // Next state, counter reload on every state entry, and next values of all registered pins.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_done ? cnt_q : cnt_q - 8'd1;
    sram_a_d     = sram_a_q;
    sram_d_out_d = sram_d_out_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          sram_a_d = req_addr;
          cnt_d    = SETUP_M1;
          if (req_write) begin
            state_d      = WR_SETUP;
            sram_d_out_d = req_wdata;
          end else begin
            state_d = RD_SETUP;
          end
        end
      end
      WR_SETUP: begin
        if (cnt_done) begin
          state_d = WR_PULSE;
          cnt_d   = WE_M1;
        end
      end
      WR_PULSE: begin
        if (cnt_done) begin
          state_d = WR_HOLD;
          cnt_d   = HOLD_M1;
        end
      end
      WR_HOLD: begin
        if (cnt_done) begin
          state_d = IDLE;
        end
      end
      RD_SETUP: begin
        if (cnt_done) begin
          state_d = RD_STROBE;
          cnt_d   = RD_M1;
        end
      end
      RD_STROBE: begin
        // Data is captured on the same edge that releases OE, while the SRAM still drives it.
        if (cnt_done) begin
          state_d     = RD_TURN;
          cnt_d       = HOLD_M1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = sram_d_in;
        end
      end
      RD_TURN: begin
        if (cnt_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Strobes are decoded from the next state so they are registered and never overlap.
    sram_cs_n_d = (state_d == IDLE);
    sram_we_n_d = (state_d != WR_PULSE);
    sram_oe_n_d = (state_d != RD_STROBE);
    sram_d_oe_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
  end

  // State, counter and output registers; reset parks every pin inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      sram_a_q     <= 16'd0;
      sram_d_out_q <= 8'd0;
      sram_d_oe_q  <= 1'b0;
      sram_cs_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sram_a_q     <= sram_a_d;
      sram_d_out_q <= sram_d_out_d;
      sram_d_oe_q  <= sram_d_oe_d;
      sram_cs_n_q  <= sram_cs_n_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sram_a     = sram_a_q;
  assign sram_d_out = sram_d_out_q;
  assign sram_d_oe  = sram_d_oe_q;
  assign sram_cs_n  = sram_cs_n_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_oe_n  = sram_oe_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - scoreboard bench for sram_ctrl with an SRAM model and a second timing instance
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        req_ready, rsp_valid;
  logic [7:0]  rsp_rdata, sram_d_out, sram_d_in;
  logic [15:0] sram_a;
  logic        sram_d_oe, sram_cs_n, sram_we_n, sram_oe_n;

  logic        req_valid_2 = 1'b0, req_write_2 = 1'b0;
  logic [15:0] req_addr_2 = 16'd0;
  logic [7:0]  req_wdata_2 = 8'd0;
  logic        req_ready_2, rsp_valid_2;
  logic [7:0]  rsp_rdata_2, sram_d_out_2, sram_d_in_2;
  logic [15:0] sram_a_2;
  logic        sram_d_oe_2, sram_cs_n_2, sram_we_n_2, sram_oe_n_2;

  int n_checks = 0, n_errors = 0, cyc = 0, viol = 0, viol_2 = 0, rsp2_cnt = 0, last_acc = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];
  int   gap_q[$];

  logic [7:0] mem [0:65535];

  sram_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_a(sram_a),
    .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe), .sram_d_in(sram_d_in),
    .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_ctrl #(.SETUP(2), .WE_WIDTH(1), .RD_WAIT(4), .HOLD(2)) u_dut_2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_2), .req_ready(req_ready_2),
    .req_write(req_write_2), .req_addr(req_addr_2), .req_wdata(req_wdata_2),
    .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2), .sram_a(sram_a_2),
    .sram_d_out(sram_d_out_2), .sram_d_oe(sram_d_oe_2), .sram_d_in(sram_d_in_2),
    .sram_cs_n(sram_cs_n_2), .sram_we_n(sram_we_n_2), .sram_oe_n(sram_oe_n_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM model: drives data while CS and OE are low, latches on WE rising.
  assign sram_d_in   = (!sram_cs_n && !sram_oe_n) ? mem[sram_a] : 8'h00;
  assign sram_d_in_2 = (!sram_cs_n_2 && !sram_oe_n_2) ? (sram_a_2[7:0] ^ 8'h5A) : 8'h00;

  always @(posedge sram_we_n) begin
    if (rst_n && !sram_cs_n) begin
      if (!sram_d_oe) viol++;
      mem[sram_a] = sram_d_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window statistics for the default instance, sampled mid-cycle.
  int cs_len = 0, we_len = 0, we_first = 0, doe_cnt = 0, gap = 0;
  int last_cs_len = 0, last_we_len = 0, last_we_first = 0, last_doe_cnt = 0;
  logic [15:0] win_a = 16'd0, last_a = 16'd0;
  logic [7:0]  win_d = 8'd0;
  logic        prev_cs = 1'b1;

  always @(negedge clk) begin
    if (!sram_cs_n) begin
      if (prev_cs) begin
        gap_q.push_back(gap);
        cs_len = 0; we_len = 0; we_first = 0; doe_cnt = 0;
        win_a = sram_a; win_d = sram_d_out;
      end
      cs_len++;
      if (!sram_we_n) begin
        we_len++;
        if (we_first == 0) we_first = cs_len;
      end
      if (sram_d_oe) doe_cnt++;
      if (sram_a !== win_a || sram_d_out !== win_d) viol++;
    end else begin
      if (!prev_cs) begin
        last_cs_len = cs_len; last_we_len = we_len; last_we_first = we_first;
        last_doe_cnt = doe_cnt; last_a = win_a;
      end
      gap = prev_cs ? gap + 1 : 1;
    end
    if (!sram_we_n && !sram_oe_n) viol++;
    if (sram_d_oe && !sram_oe_n) viol++;
    if ((!sram_we_n || !sram_oe_n || sram_d_oe) && sram_cs_n) viol++;
    if (!sram_we_n_2 && !sram_oe_n_2) viol_2++;
    if (sram_d_oe_2 && !sram_oe_n_2) viol_2++;
    if ((!sram_we_n_2 || !sram_oe_n_2 || sram_d_oe_2) && sram_cs_n_2) viol_2++;
    if (rsp_valid_2) rsp2_cnt++;
    prev_cs = sram_cs_n;
  end

  // Scoreboard: every response pops the oldest expected read and checks data and arrival cycle.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Present a request and keep req_valid high until the accepting edge; reads push an expectation.
  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (!w) exp_q.push_back('{data: exp_rd, cyc: last_acc + 3});
  endtask

  task automatic wait_idle();
    int n = 0;
    req_valid = 1'b0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(req_ready && sram_cs_n && exp_q.size() == 0) && n < 200);
    if (n >= 200) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int n, acc, cs_cnt, we_cnt;
    repeat (3) @(negedge clk);
    chk("rst_pins", {26'd0, sram_cs_n, sram_we_n, sram_oe_n, sram_d_oe, rsp_valid, req_ready}, 32'b111001);
    chk("rst_bus", {8'd0, sram_a, sram_d_out}, 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;

    // Default write: timing of the CS window and ready return.
    send(1'b1, 16'h1234, 8'hA5, 8'h00);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!req_ready && n < 50);
    chk("wr_ready_lat", 32'(cyc - last_acc), 32'd4);
    wait_idle();
    chk("wr_cs_len", 32'(last_cs_len), 32'd4);
    chk("wr_we_first", 32'(last_we_first), 32'd2);
    chk("wr_we_len", 32'(last_we_len), 32'd2);
    chk("wr_doe_len", 32'(last_doe_cnt), 32'd4);
    chk("wr_addr", 32'(last_a), 32'h1234);
    chk("wr_mem", 32'(mem[16'h1234]), 32'hA5);

    // Default read back.
    send(1'b0, 16'h1234, 8'h00, 8'hA5);
    wait_idle();
    chk("rd_doe_len", 32'(last_doe_cnt), 32'd0);
    chk("rd_cs_len", 32'(last_cs_len), 32'd4);

    // Back-to-back with req_valid held high throughout.
    gap_q.delete();
    send(1'b1, 16'h0001, 8'h11, 8'h00);
    send(1'b0, 16'h0001, 8'h00, 8'h11);
    send(1'b1, 16'h0002, 8'h22, 8'h00);
    wait_idle();
    chk("b2b_windows", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      chk("b2b_gap_rw", 32'(gap_q[1]), 32'd1);
      chk("b2b_gap_ww", 32'(gap_q[2]), 32'd1);
    end
    chk("b2b_mem2", 32'(mem[16'h0002]), 32'h22);
    chk("rdata_hold", 32'(rsp_rdata), 32'h11);

    // Address extremes pass through unchanged.
    send(1'b1, 16'hFFFF, 8'h3C, 8'h00);
    wait_idle();
    chk("addr_ffff", 32'(last_a), 32'hFFFF);
    send(1'b1, 16'h0000, 8'hC3, 8'h00);
    wait_idle();
    chk("addr_0000", 32'(last_a), 32'h0000);
    send(1'b0, 16'hFFFF, 8'h00, 8'h3C);
    send(1'b0, 16'h0000, 8'h00, 8'hC3);
    wait_idle();
    chk("addr_rd_0000", 32'(last_a), 32'h0000);

    // Asynchronous reset in the middle of the WE pulse.
    send(1'b1, 16'h5555, 8'h77, 8'h00);
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sram_we_n && n < 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pins", {27'd0, sram_cs_n, sram_we_n, sram_oe_n, sram_d_oe, req_ready}, 32'b11101);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 16'h1234, 8'h00, 8'hA5);
    wait_idle();

    // Second instance: SETUP=2, WE_WIDTH=1, RD_WAIT=4, HOLD=2.
    @(negedge clk);
    req_valid_2 = 1'b1; req_write_2 = 1'b1; req_addr_2 = 16'h00C3; req_wdata_2 = 8'h42;
    @(posedge clk);
    #1;
    req_valid_2 = 1'b0;
    cs_cnt = 0; we_cnt = 0; n = 0;
    do begin
      @(negedge clk);
      if (!sram_cs_n_2) cs_cnt++;
      if (!sram_we_n_2) we_cnt++;
      n++;
    end while (!sram_cs_n_2 && n < 50);
    chk("p2_wr_cs_len", 32'(cs_cnt), 32'd5);
    chk("p2_wr_we_len", 32'(we_cnt), 32'd1);
    @(negedge clk);
    req_valid_2 = 1'b1; req_write_2 = 1'b0;
    @(posedge clk);
    #1;
    req_valid_2 = 1'b0;
    acc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid_2 && n < 50);
    chk("p2_rsp_lat", 32'(cyc - acc), 32'd6);
    chk("p2_rdata", 32'(rsp_rdata_2), 32'(8'hC3 ^ 8'h5A));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_2 && n < 50);
    chk("p2_ready_lat", 32'(cyc - acc), 32'd8);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("invariants", 32'(viol), 32'd0);
    chk("invariants_p2", 32'(viol_2), 32'd0);
    chk("p2_rsp_count", 32'(rsp2_cnt), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
